// File: rtl/uart_rx_core.sv
// UART receive engine: oversampled start detect, mid-bit sampling, LSB-first data, stop check.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx_core #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 Sys_CLK,
  input  logic                 Sys_RST,
  input  logic                 Signal_Rx,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_Valid,
  output logic                 Rx_Frame_Err,
  output logic                 Rx_Busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 Rx_Parity_Err
`endif
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] data_sr_reg, data_sr_next;
  logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
  logic                 valid_reg, valid_next;
  logic                 ferr_reg, ferr_next;
  logic                 sync1_reg, sync2_reg, hist_reg;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_reg, par_bad_next;
  logic                 perr_reg, perr_next;
`endif

  // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      hist_reg  <= 1'b1;
    end else begin
      sync1_reg <= Signal_Rx;
      sync2_reg <= sync1_reg;
      hist_reg  <= sync2_reg;
    end
  end

  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      data_sr_reg <= '0;
      rx_data_reg <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg <= 1'b0;
      perr_reg    <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      data_sr_reg <= data_sr_next;
      rx_data_reg <= rx_data_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
`ifdef UART_RX_PARITY_EN
      par_bad_reg <= par_bad_next;
      perr_reg    <= perr_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    data_sr_next = data_sr_reg;
    rx_data_next = rx_data_reg;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next = par_bad_reg;
    perr_next    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (hist_reg && !sync2_reg) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        // Half-bit check rejects short low glitches on the idle line.
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (!sync2_reg) begin
            state_next = DATA;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_reg == BAUD_LAST) begin
          cnt_next              = '0;
          data_sr_next[idx_reg] = sync2_reg;
          idx_next              = idx_reg + IDX_W'(1);
          if (idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_reg == BAUD_LAST) begin
          cnt_next     = '0;
          par_bad_next = (^data_sr_reg) ^ sync2_reg;
          state_next   = STOP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_reg == BAUD_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (sync2_reg) begin
            rx_data_next = data_sr_reg;
            valid_next   = 1'b1;
          end else begin
            ferr_next = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          perr_next = par_bad_reg;
`endif
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign Rx_Data      = rx_data_reg;
  assign Rx_Valid     = valid_reg;
  assign Rx_Frame_Err = ferr_reg;
  assign Rx_Busy      = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign Rx_Parity_Err = perr_reg;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: frame-level reference model with an event scoreboard.
// Covers parity frames too when UART_RX_PARITY_EN is defined.
module tb_uart_rx_core;

  localparam int BAUD_DIV  = 10;
  localparam int HALF_DIV  = BAUD_DIV / 2;
  localparam int DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int LATENCY = 2 + HALF_DIV + (DATA_BITS + 1 + NPAR) * BAUD_DIV;

  logic       Sys_CLK   = 1'b0;
  logic       Sys_RST   = 1'b0;
  logic       Signal_Rx = 1'b0;
  logic [7:0] Rx_Data;
  logic       Rx_Valid, Rx_Frame_Err, Rx_Busy;
  logic       Rx_Parity_Err;

  uart_rx_core #(
    .CLK_FREQ (50_000_000),
    .BAUD_RATE(5_000_000),
    .DATA_BITS(DATA_BITS)
  ) dut (
    .Sys_CLK     (Sys_CLK),
    .Sys_RST     (Sys_RST),
    .Signal_Rx   (Signal_Rx),
    .Rx_Data     (Rx_Data),
    .Rx_Valid    (Rx_Valid),
    .Rx_Frame_Err(Rx_Frame_Err),
    .Rx_Busy     (Rx_Busy)
`ifdef UART_RX_PARITY_EN
    ,
    .Rx_Parity_Err(Rx_Parity_Err)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign Rx_Parity_Err = 1'b0;
`endif

  always #10 Sys_CLK = ~Sys_CLK;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic       perr;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  int         checks   = 0;
  int         errors   = 0;
  int         cyc      = 0;
  int         busy_cnt = 0;
  logic [7:0] rx_data_model = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  always @(posedge Sys_CLK) cyc <= cyc + 1;

  always @(negedge Sys_CLK) begin : monitor
    ev_t e;
    if (Rx_Busy) busy_cnt++;
    if (Rx_Valid || Rx_Frame_Err) begin
      e.is_err = Rx_Frame_Err;
      e.data   = Rx_Data;
      e.perr   = Rx_Parity_Err;
      e.cyc    = cyc;
      obs_q.push_back(e);
      chk("pulse_exclusive", {31'b0, Rx_Valid & Rx_Frame_Err}, 32'd0);
    end
  end

  task automatic align();
    @(posedge Sys_CLK);
    #1;
  endtask

  task automatic idle(input int n, input logic level);
    Signal_Rx = level;
    repeat (n) @(posedge Sys_CLK);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    Signal_Rx = b;
    repeat (BAUD_DIV) @(posedge Sys_CLK);
    #1;
  endtask

  // Reference model: a good stop yields the byte, a low stop yields an error with data held.
  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit bad_par);
    ev_t e;
    e.cyc    = cyc;
    e.is_err = !stop_bit;
    if (stop_bit) rx_data_model = d;
    e.data = rx_data_model;
`ifdef UART_RX_PARITY_EN
    e.perr = bad_par;
`else
    e.perr = 1'b0;
`endif
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic flush(input string tag);
    int n;
    int lat;
    n = exp_q.size();
    chk({tag, "_count"}, obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      chk({tag, "_kind"}, {31'b0, obs_q[i].is_err}, {31'b0, exp_q[i].is_err});
      chk({tag, "_data"}, {24'b0, obs_q[i].data}, {24'b0, exp_q[i].data});
      chk({tag, "_perr"}, {31'b0, obs_q[i].perr}, {31'b0, exp_q[i].perr});
      if (exp_q[i].cyc >= 0) begin
        lat = obs_q[i].cyc - exp_q[i].cyc;
        chk({tag, "_latency_ok"}, {31'b0, (lat >= LATENCY - 1 && lat <= LATENCY + 1)}, 32'd1);
      end
      $display("%s: event %s data=%02h perr=%0b at cycle %0d",
               tag, obs_q[i].is_err ? "frame_err" : "valid", obs_q[i].data, obs_q[i].perr, obs_q[i].cyc);
    end
    exp_q.delete();
    obs_q.delete();
    chk({tag, "_rx_data"}, {24'b0, Rx_Data}, {24'b0, rx_data_model});
  endtask

  initial begin : stim
    ev_t        e;
    int         b0;
    logic       seen;
    logic [7:0] d;

    // Reset with the line held low throughout
    repeat (5) @(posedge Sys_CLK);
    #1;
    chk("reset_rx_data", {24'b0, Rx_Data}, 32'd0);
    chk("reset_valid", {31'b0, Rx_Valid}, 32'd0);
    chk("reset_frame_err", {31'b0, Rx_Frame_Err}, 32'd0);
    chk("reset_busy", {31'b0, Rx_Busy}, 32'd0);
    Sys_RST = 1'b1;
    e.is_err = 1'b1; e.data = 8'h00; e.perr = 1'b0; e.cyc = -1;
    exp_q.push_back(e);
    idle(300, 1'b0);
    flush("low_through_reset");
    idle(20, 1'b1);

    // Single frame and busy window
    b0 = busy_cnt;
    send_frame(8'h55, 1'b1, 1'b0);
    idle(20, 1'b1);
    chk("busy_window_ok", {31'b0, (busy_cnt - b0 >= 90 && busy_cnt - b0 <= 115)}, 32'd1);
    chk("busy_low_after", {31'b0, Rx_Busy}, 32'd0);
    flush("frame_55");

    // Back-to-back frames
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(20, 1'b1);
    flush("back_to_back");

    // Framing error followed by a held-low break
    send_frame(8'hC6, 1'b0, 1'b0);
    idle(300, 1'b0);
    flush("break");
    idle(20, 1'b1);

    // Short glitch on idle line
    seen = 1'b0;
    Signal_Rx = 1'b0;
    repeat (3) @(posedge Sys_CLK);
    #1;
    Signal_Rx = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge Sys_CLK);
      seen = seen | Rx_Busy;
    end
    align();
    chk("glitch_busy_seen", {31'b0, seen}, 32'd1);
    chk("glitch_busy_clear", {31'b0, Rx_Busy}, 32'd0);
    flush("glitch");

    // Reset mid-frame during data bit 4
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    Signal_Rx = 1'b0;
    repeat (5) @(posedge Sys_CLK);
    #1;
    Sys_RST = 1'b0;
    #1;
    chk("midrst_rx_data", {24'b0, Rx_Data}, 32'd0);
    chk("midrst_busy", {31'b0, Rx_Busy}, 32'd0);
    chk("midrst_valid", {31'b0, Rx_Valid}, 32'd0);
    chk("midrst_frame_err", {31'b0, Rx_Frame_Err}, 32'd0);
    rx_data_model = 8'h00;
    Signal_Rx = 1'b1;
    repeat (3) @(posedge Sys_CLK);
    #1;
    Sys_RST = 1'b1;
    idle(20, 1'b1);
    flush("mid_reset");
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20, 1'b1);
    flush("after_reset_3c");

    // Random back-to-back good frames
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, 1'($urandom_range(0, 1)));
    end
    idle(20, 1'b1);
    flush("random_burst");

    // Random frames with occasional bad stop bit
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      send_frame(d, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      idle(20, 1'b1);
      flush("random_stop");
    end

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20, 1'b1);
    flush("parity_good");
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20, 1'b1);
    flush("parity_bad");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
